// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

  localparam int unsigned DIV_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter width; at least one bit for the smallest legal width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/borrow_subtractor.sv
// Combinational a - b in propagate/generate form; borrow_o set when a < b.
module borrow_subtractor #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;

  // Subtraction as a + ~b + 1, so the carry-in is 1 and borrow is the inverted carry-out.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign p[i]      = a_i[i] ^ ~b_i[i];
    assign g[i]      = a_i[i] & ~b_i[i];
    assign diff_o[i] = p[i] ^ c[i];
  end

  always_comb begin
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign borrow_o = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             dbz_d, ov_d;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic             unused_r_msb;

  // R stays below D after every iteration, so its top bit never feeds back.
  assign unused_r_msb = r_q[WIDTH];

  assign s          = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign in_ready_o = (state_q == IDLE) && !rst_i;

  borrow_subtractor #(.N(WIDTH + 1)) u_sub (
    .a_i     (s),
    .b_i     ({1'b0, d_q}),
    .diff_o  (t),
    .borrow_o(borrow)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quotient_o;
    rem_d   = remainder_o;
    dbz_d   = div_by_zero_o;
    ov_d    = out_valid_o;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          if (divisor_i == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            ov_d    = 1'b1;
          end else begin
            state_d = BUSY;
            q_d     = dividend_i;
            r_d     = '0;
            d_d     = divisor_i;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        r_d   = borrow ? s : t;
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          ov_d    = 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          ov_d    = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      q_q           <= '0;
      r_q           <= '0;
      d_q           <= '0;
      cnt_q         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      out_valid_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      r_q           <= r_d;
      d_q           <= d_d;
      cnt_q         <= cnt_d;
      quotient_o    <= quot_d;
      remainder_o   <= rem_d;
      div_by_zero_o <= dbz_d;
      out_valid_o   <= ov_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=16): timing, edge cases, backpressure, reset abort.
module tb_seq_divider;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] dividend_i;
  logic [15:0] divisor_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] quotient_o;
  logic [15:0] remainder_o;
  logic        div_by_zero_o;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction; cycle 0 is the accept cycle, latency counts cycles until out_valid_o.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edbz, input int elat, input string tag,
                        output logic [15:0] q, output logic [15:0] r);
    int cyc;
    cyc = 0;
    while (!in_ready_o && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, " ready before accept"}, 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    tick();
    in_valid_i = 1'b0;
    dividend_i = 16'hdead;
    divisor_i  = 16'h0000;
    check({tag, " in_ready after accept"}, 32'(in_ready_o), 32'd0);
    cyc = 1;
    while (!out_valid_o && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(elat));
    check({tag, " quotient"}, 32'(quotient_o), 32'(eq));
    check({tag, " remainder"}, 32'(remainder_o), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero_o), 32'(edbz));
    q = quotient_o;
    r = remainder_o;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(out_valid_o), 32'd0);
    check({tag, " div_by_zero after handshake"}, 32'(div_by_zero_o), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    logic [15:0] q, r, a, b;
    int          cyc;
    logic        seen;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    tick();
    tick();
    check("reset in_ready", 32'(in_ready_o), 32'd0);
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset quotient", 32'(quotient_o), 32'd0);
    check("reset remainder", 32'(remainder_o), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("in_ready after reset release", 32'(in_ready_o), 32'd1);

    do_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, "100/7", q, r);
    do_div(16'hffff, 16'h0001, 16'hffff, 16'h0000, 1'b0, 17, "ffff/1", q, r);
    do_div(16'hffff, 16'hffff, 16'h0001, 16'h0000, 1'b0, 17, "ffff/ffff", q, r);
    do_div(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, "3/10", q, r);
    do_div(16'd5, 16'd0, 16'hffff, 16'd5, 1'b1, 1, "5/0", q, r);
    do_div(16'd0, 16'd9, 16'd0, 16'd0, 1'b0, 17, "0/9", q, r);
    do_div(16'd40000, 16'd256, 16'd156, 16'd64, 1'b0, 17, "40000/256", q, r);

    // Backpressure: result must hold and new operands must be ignored.
    in_valid_i = 1'b1;
    dividend_i = 16'd1000;
    divisor_i  = 16'd33;
    tick();
    in_valid_i = 1'b0;
    cyc = 1;
    while (!out_valid_o && cyc < 40) begin
      tick();
      cyc++;
    end
    check("1000/33 latency", 32'(cyc), 32'd17);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = i[0];
      dividend_i = 16'(i * 77);
      divisor_i  = 16'(i + 2);
      check("bp out_valid", 32'(out_valid_o), 32'd1);
      check("bp quotient", 32'(quotient_o), 32'd30);
      check("bp remainder", 32'(remainder_o), 32'd10);
      check("bp in_ready", 32'(in_ready_o), 32'd0);
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("bp release out_valid", 32'(out_valid_o), 32'd0);
    check("bp release in_ready", 32'(in_ready_o), 32'd1);

    // Reset in the middle of BUSY aborts the operation.
    in_valid_i = 1'b1;
    dividend_i = 16'd200;
    divisor_i  = 16'd3;
    tick();
    in_valid_i = 1'b0;
    repeat (8) tick();
    check("mid-op busy", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check("in_ready during reset", 32'(in_ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid_o), 32'd0);
    check("abort quotient", 32'(quotient_o), 32'd0);
    check("abort remainder", 32'(remainder_o), 32'd0);
    check("abort div_by_zero", 32'(div_by_zero_o), 32'd0);
    check("abort in_ready", 32'(in_ready_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o) seen = 1'b1;
      tick();
    end
    check("aborted result never delivered", 32'(seen), 32'd0);
    do_div(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17, "50/5 after abort", q, r);

    // Pseudo-random pairs against a reference divide and the division invariant.
    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      b = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      do_div(a, b, a / b, a % b, 1'b0, 17, "random", q, r);
      check("invariant q*d+r", 32'(q) * 32'(b) + 32'(r), 32'(a));
      check("invariant r<d", 32'(r < b), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
